sha3_job_ctrl: RTL and testbench
================================

// Module: sha3_job_ctrl
// PURPOSE
//  Wishbone-slave job sequencer in front of the sha3 hashing core inside the user project area.
//  Firmware programs a byte length and pushes message words into an input FIFO, then writes START.
//  The FSM streams the words into the core, captures the serial digest, and raises done/irq.
// PARAMETERS
//  BASE_ADDR     32'h3000_0000  Wishbone base; decode on wbs_adr_i[31:8]
//  FIFO_DEPTH    8              input FIFO depth in 32-bit words (power of 2, >=2)
//  DIGEST_WORDS  8              32-bit digest words captured from the core (8 = SHA3-256)
// PORTS
//  wb_clk_i       in   1   sole clock
//  wb_rst_i       in   1   synchronous, active-high reset
//  wbs_cyc_i      in   1   Wishbone cycle
//  wbs_stb_i      in   1   Wishbone strobe
//  wbs_we_i       in   1   Wishbone write enable
//  wbs_sel_i      in   4   byte selects; writes take effect only when sel==4'hF
//  wbs_adr_i      in   32  byte address
//  wbs_dat_i      in   32  write data
//  wbs_ack_o      out  1   acknowledge
//  wbs_dat_o      out  32  read data
//  core_start_o   out  1   one-cycle job-start pulse to the core
//  core_abort_o   out  1   one-cycle abort pulse to the core
//  core_len_o     out  16  message byte length; held for the whole job
//  core_valid_o   out  1   message word valid
//  core_dat_o     out  32  message word, little-endian bytes
//  core_last_o    out  1   marks the final message word
//  core_ready_i   in   1   core accepts a word when valid&ready
//  core_dig_valid_i in 1   digest word strobe, DIGEST_WORDS strobes per job
//  core_dig_dat_i in   32  digest word, word 0 first
//  irq_o          out  1   job-complete interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Reset: wbs_ack_o=0, wbs_dat_o=0, all core_* outputs=0, irq_o=0; FSM=IDLE; FIFO empty; LEN=0; digest regs=0; status bits=0.
//  WB: a hit (cyc&stb&~ack, address match) acks exactly 1 cycle later for 1 cycle. Unmapped offsets ack and read 0.
//  Regs (offset): 0x00 CTRL W: b0 START, b1 ABORT, self-clearing, reads 0.
//   0x04 STATUS R: b0 busy, b1 done, b2 full, b3 empty, b4 ovf_err, b5 start_err; W1C on b1, b4, b5.
//   0x08 LEN RW [15:0]; writes are ignored while busy. 0x0C DATA W: push to FIFO.
//   0x20+4*i DIGEST[i] R.
//  FIFO: push to a full FIFO is dropped and sets ovf_err. Push and pop in the same cycle on a full FIFO:
//   the pop frees the slot first, so the push is accepted.
//  nwords = ceil(LEN/4); the unused high bytes of the last word are passed through unmodified.
//   The core pads.
//  FSM IDLE: on START, clear the digest regs and done, pulse core_start_o, and latch nwords into a counter.
//   Then go to ABSORB, or to WAIT_DIG if LEN==0. START while busy is ignored and sets start_err.
//  ABSORB: core_valid_o = ~fifo_empty; core_dat_o = FIFO head; core_last_o = (cnt==1).
//   Each valid&ready pops the FIFO and decrements cnt; the transfer with last moves to WAIT_DIG.
//   An empty FIFO stalls indefinitely; there is no timeout.
//  WAIT_DIG: each core_dig_valid_i writes DIGEST[idx] and increments idx.
//   The DIGEST_WORDS-th strobe moves to DONE. Strobes in any other state are ignored.
//  DONE (1 cycle): set done, busy=0, return to IDLE.
//  ABORT (any state, takes priority over START in the same write): pulse core_abort_o, flush the FIFO, go IDLE.
//   done is not set; error bits are kept.
//  busy = (state != IDLE). A wb_rst_i assertion mid-job returns every register to its reset value next cycle.
// CONFIGURATION
//  SHA3_JOB_IRQ_EN defined: adds IRQ_MASK reg at 0x10 (b0, RW, reset 0). irq_o = done & mask, level;
//   it clears when done is W1C-cleared.
//  SHA3_JOB_IRQ_EN undefined: no mask reg; 0x10 reads 0; irq_o tied 0.
// STRUCTURE
//  Package sha3_job_pkg: FSM state enum (IDLE, ABSORB, WAIT_DIG, DONE), register offset constants,
//   STATUS bit indices.
//  One sub-module: sha3_job_fifo (sync FIFO, DEPTH param, full/empty, same-cycle push/pop).
// TESTING
//  1. LEN=5, push 0x64636261 and 0x00000065, START -> 2 core beats, last on beat 2;
//   after 8 dig strobes, DIGEST[0..7] match the core model, done=1, busy=0.
//  2. LEN=0, START -> no core_valid_o; core_start_o pulse; 8 dig strobes -> done=1.
//  3. Push 9 words with FIFO_DEPTH=8 while idle -> full=1, ovf_err=1, 9th word lost; W1C 0x10 clears ovf_err.
//  4. Mid-ABSORB with core_ready_i held 0, write CTRL=0x2 -> core_abort_o pulse, FIFO empty=1, busy=0, done=0.
//  5. START while busy -> start_err=1, job continues unaffected; wb_rst_i for 1 cycle mid-WAIT_DIG -> all status 0.
//  6. With SHA3_JOB_IRQ_EN: mask=1, job completes -> irq_o=1; write STATUS=0x2 -> irq_o=0 next cycle.

Source files
------------

// File: rtl/sha3_job_pkg.sv
// Shared definitions for the sha3 job sequencer: FSM states, register map
// offsets, STATUS bit positions and the byte-length to word-count helper.
package sha3_job_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ABSORB   = 2'd1,
        WAIT_DIG = 2'd2,
        DONE     = 2'd3
    } job_state_e;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_LEN      = 8'h08;
    localparam logic [7:0] OFF_DATA     = 8'h0C;
    localparam logic [7:0] OFF_IRQ_MASK = 8'h10;
    localparam logic [7:0] OFF_DIGEST   = 8'h20;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_EMPTY     = 3;
    localparam int STAT_OVF_ERR   = 4;
    localparam int STAT_START_ERR = 5;

    // Number of 32-bit message words needed to carry len bytes.
    function automatic logic [15:0] len_to_words(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd3;
        return {1'b0, sum[16:2]};
    endfunction

endpackage

// File: rtl/sha3_job_fifo.sv
// Synchronous word FIFO feeding message words to the core. A pop in the same
// cycle as a push frees a slot first, so a push into a full FIFO is accepted
// when it coincides with a pop. flush empties the FIFO immediately.
module sha3_job_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sha3_job_ctrl.sv
// Wishbone-slave job sequencer in front of the sha3 core. Firmware loads a
// byte length, pushes message words, writes START; the FSM streams the words
// into the core, captures the digest words, then flags done.
// Optional feature macro: SHA3_JOB_IRQ_EN adds the IRQ_MASK register at 0x10
// and drives irq_o = done & mask; without it irq_o is tied low.
// Core handshake: a message word moves when core_valid_o & core_ready_i are
// both high at a clock edge; valid never depends on ready.
module sha3_job_ctrl
    import sha3_job_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          DIGEST_WORDS = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        core_start_o,
    output logic        core_abort_o,
    output logic [15:0] core_len_o,
    output logic        core_valid_o,
    output logic [31:0] core_dat_o,
    output logic        core_last_o,
    input  logic        core_ready_i,
    input  logic        core_dig_valid_i,
    input  logic [31:0] core_dig_dat_i,
    output logic        irq_o
);
    localparam int DIG_IW = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;

    job_state_e        state_q, state_d;
    logic [15:0]       len_q;
    logic [15:0]       cnt_q;
    logic [DIG_IW-1:0] dig_idx_q;
    logic [31:0]       dig_q [DIGEST_WORDS];
    logic              done_q, ovf_q, start_err_q;
    logic              ack_q, start_pulse_q, abort_pulse_q;
    logic [31:0]       dat_q, rdata;
    logic              mask_q;

    logic [7:0]  off;
    logic        wb_hit, wr_en, start_cmd, abort_cmd, status_wr, busy;
    logic        fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [31:0] fifo_dout;
    logic        job_start, job_start_err, dig_wr, beat;

    assign off       = wbs_adr_i[7:0];
    assign wb_hit    = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr_en     = wb_hit & wbs_we_i & (wbs_sel_i == 4'hF);
    assign start_cmd = wr_en & (off == OFF_CTRL) & wbs_dat_i[0];
    assign abort_cmd = wr_en & (off == OFF_CTRL) & wbs_dat_i[1];
    assign status_wr = wr_en & (off == OFF_STATUS);
    assign fifo_push = wr_en & (off == OFF_DATA);
    assign busy      = (state_q != IDLE);

    sha3_job_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wbs_dat_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state logic and core-side stream outputs; ABORT overrides everything.
    always_comb begin
        state_d       = state_q;
        job_start     = 1'b0;
        job_start_err = 1'b0;
        dig_wr        = 1'b0;
        fifo_flush    = 1'b0;
        core_valid_o  = (state_q == ABSORB) & ~fifo_empty;
        core_dat_o    = core_valid_o ? fifo_dout : 32'h0;
        core_last_o   = core_valid_o & (cnt_q == 16'd1);
        beat          = core_valid_o & core_ready_i;
        fifo_pop      = beat;
        if (abort_cmd) begin
            state_d    = IDLE;
            fifo_flush = 1'b1;
        end else begin
            if (start_cmd) begin
                if (busy) job_start_err = 1'b1;
                else      job_start     = 1'b1;
            end
            case (state_q)
                IDLE:     if (job_start) state_d = (len_q == 16'd0) ? WAIT_DIG : ABSORB;
                ABSORB:   if (beat && cnt_q == 16'd1) state_d = WAIT_DIG;
                WAIT_DIG: begin
                    if (core_dig_valid_i) begin
                        dig_wr = 1'b1;
                        if (dig_idx_q == DIG_IW'(DIGEST_WORDS - 1)) state_d = DONE;
                    end
                end
                DONE:     state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Register read mux; unmapped offsets read zero.
    always_comb begin
        rdata = 32'h0;
        for (int i = 0; i < DIGEST_WORDS; i++) begin
            if (off == OFF_DIGEST + 8'(4 * i)) rdata = dig_q[i];
        end
        case (off)
            OFF_STATUS: begin
                rdata[STAT_BUSY]      = busy;
                rdata[STAT_DONE]      = done_q;
                rdata[STAT_FULL]      = fifo_full;
                rdata[STAT_EMPTY]     = fifo_empty;
                rdata[STAT_OVF_ERR]   = ovf_q;
                rdata[STAT_START_ERR] = start_err_q;
            end
            OFF_LEN:      rdata = {16'h0, len_q};
`ifdef SHA3_JOB_IRQ_EN
            OFF_IRQ_MASK: rdata = {31'h0, mask_q};
`endif
            default:      ;
        endcase
    end

    // FSM state, bus response, counters and status bits.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= IDLE;
            ack_q         <= 1'b0;
            dat_q         <= 32'h0;
            start_pulse_q <= 1'b0;
            abort_pulse_q <= 1'b0;
            len_q         <= 16'h0;
            cnt_q         <= 16'h0;
            dig_idx_q     <= '0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
            start_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ack_q         <= wb_hit;
            dat_q         <= (wb_hit && !wbs_we_i) ? rdata : 32'h0;
            start_pulse_q <= job_start;
            abort_pulse_q <= abort_cmd;
            if (wr_en && off == OFF_LEN && !busy) len_q <= wbs_dat_i[15:0];
            if (job_start)  cnt_q <= len_to_words(len_q);
            else if (beat)  cnt_q <= cnt_q - 16'd1;
            if (job_start)   dig_idx_q <= '0;
            else if (dig_wr) dig_idx_q <= dig_idx_q + DIG_IW'(1);
            if (state_q == DONE)                    done_q <= 1'b1;
            else if (job_start)                     done_q <= 1'b0;
            else if (status_wr && wbs_dat_i[STAT_DONE]) done_q <= 1'b0;
            if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
            else if (status_wr && wbs_dat_i[STAT_OVF_ERR]) ovf_q <= 1'b0;
            if (job_start_err) start_err_q <= 1'b1;
            else if (status_wr && wbs_dat_i[STAT_START_ERR]) start_err_q <= 1'b0;
        end
    end

    // Digest capture; a new job clears every word.
    always_ff @(posedge wb_clk_i) begin
        for (int i = 0; i < DIGEST_WORDS; i++) begin
            if (wb_rst_i || job_start)                    dig_q[i] <= 32'h0;
            else if (dig_wr && dig_idx_q == DIG_IW'(i))   dig_q[i] <= core_dig_dat_i;
        end
    end

`ifdef SHA3_JOB_IRQ_EN
    // Interrupt mask register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) mask_q <= 1'b0;
        else if (wr_en && off == OFF_IRQ_MASK) mask_q <= wbs_dat_i[0];
    end
    assign irq_o = done_q & mask_q;
`else
    assign mask_q = 1'b0;
    assign irq_o  = 1'b0;
`endif

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign core_start_o = start_pulse_q;
    assign core_abort_o = abort_pulse_q;
    assign core_len_o   = len_q;

endmodule

// File: tb/tb_sha3_job_ctrl.sv
// Bench for sha3_job_ctrl: directed jobs with a queue-based model of the
// message FIFO, beat count, length register and digest contents.
module tb_sha3_job_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, ack, core_start, core_abort, core_valid, core_last;
  logic        core_ready, dig_valid, irq;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat_o, core_dat, dig_dat;
  logic [15:0] core_len;

  // scoreboard / model state
  logic [31:0] exp_q[$];
  logic [31:0] exp_dig [8];
  logic [15:0] model_len;
  bit          model_busy;
  bit          chk_en;
  int          beats_left, beats_seen, valid_cycles, start_pulses, abort_pulses;
  int          n_cmp, n_err;

  sha3_job_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
    .core_start_o(core_start), .core_abort_o(core_abort), .core_len_o(core_len),
    .core_valid_o(core_valid), .core_dat_o(core_dat), .core_last_o(core_last),
    .core_ready_i(core_ready), .core_dig_valid_i(dig_valid), .core_dig_dat_i(dig_dat),
    .irq_o(irq)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish before 300us");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic wb_cycle(input logic w, input logic [7:0] off, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
    int waited;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = BASE | {24'h0, off}; wdat = d; sel = s;
    @(posedge clk); #1;
    waited = 1;
    while (!ack && waited < 5) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ack_latency", waited, 1);
    r = rdat_o;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] r;
    wb_cycle(1'b1, off, d, s, r);
    if (s == 4'hF && off == 8'h0C && exp_q.size() < 8) exp_q.push_back(d);
    if (s == 4'hF && off == 8'h08 && !model_busy) model_len = d[15:0];
  endtask

  task automatic wb_read_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb_cycle(1'b0, off, 32'h0, 4'hF, r);
    check(name, r, exp);
  endtask

  task automatic dig_strobes(input int n, input logic [31:0] base, input bit rec);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      dig_valid = 1; dig_dat = base + i;
      if (rec) exp_dig[i] = base + i;
    end
    @(posedge clk); #1;
    dig_valid = 0; dig_dat = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (beats_left != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, beats_left, 0);
  endtask

  task automatic start_job(input int nwords);
    wb_write(8'h00, 32'h1);
    beats_left = nwords;
    model_busy = 1;
  endtask

  // compare process: every stream beat against the model FIFO, plus length/irq/valid
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (core_start) start_pulses++;
      if (core_abort) abort_pulses++;
      if (core_valid) valid_cycles++;
      check("core_len", {16'h0, core_len}, {16'h0, model_len});
`ifndef SHA3_JOB_IRQ_EN
      check("irq_tied", {31'h0, irq}, 32'h0);
`endif
      if (beats_left == 0) check("no_valid_without_words", {31'h0, core_valid}, 32'h0);
      if (core_valid && core_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL beat_unexpected: got beat %h expected none", core_dat);
        end else begin
          check("beat_data", core_dat, exp_q.pop_front());
          check("beat_last", {31'h0, core_last}, {31'h0, beats_left == 1});
          beats_left--;
          beats_seen++;
        end
      end
    end
  end

  initial begin
    int b0, v0, s0, a0;
    rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    core_ready = 0; dig_valid = 0; dig_dat = 0;
    model_len = 0; model_busy = 0; chk_en = 0; beats_left = 0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dat", rdat_o, 32'h0);
    check("rst_core_ctl", {26'h0, core_start, core_abort, core_valid, core_last, irq, 1'b0}, 32'h0);
    check("rst_core_dat", core_dat, 32'h0);
    check("rst_core_len", {16'h0, core_len}, 32'h0);
    rst = 0; chk_en = 1;
    wb_read_chk("rst_status", 8'h04, 32'h08);
    wb_read_chk("rst_len", 8'h08, 32'h0);
    wb_read_chk("ctrl_reads0", 8'h00, 32'h0);
    wb_read_chk("off10_reads0", 8'h10, 32'h0);
    wb_read_chk("unmapped_reads0", 8'h44, 32'h0);
    wb_read_chk("rst_digest3", 8'h2C, 32'h0);

    // 1: LEN=5, two words, two beats
    core_ready = 1;
    wb_write(8'h08, 32'h5);
    wb_write(8'h08, 32'h1234, 4'h3);
    wb_read_chk("len_partial_sel_ignored", 8'h08, 32'h5);
    wb_write(8'h0C, 32'h6463_6261);
    wb_write(8'h0C, 32'h0000_0065);
    b0 = beats_seen;
    start_job(2);
    wait_drain("t1_drain");
    check("t1_beats", beats_seen - b0, 2);
    idle_cycles(2);
    wb_read_chk("t1_status_busy", 8'h04, 32'h09);
    dig_strobes(8, 32'hC0DE_0100, 1);
    idle_cycles(3);
    model_busy = 0;
    wb_read_chk("t1_status_done", 8'h04, 32'h0A);
    for (int i = 0; i < 8; i++) wb_read_chk("t1_digest", 8'h20 + 8'(4 * i), exp_dig[i]);
    wb_read_chk("t1_digest0_lit", 8'h20, 32'hC0DE_0100);
    wb_read_chk("t1_digest7_lit", 8'h3C, 32'hC0DE_0107);
    check("t1_start_pulses", start_pulses, 1);
    dig_strobes(1, 32'hBAD0_0000, 0);
    wb_read_chk("idle_strobe_ignored", 8'h20, 32'hC0DE_0100);

    // 2: LEN=0 goes straight to digest wait
    wb_write(8'h08, 32'h0);
    v0 = valid_cycles;
    start_job(0);
    wb_read_chk("t2_status_busy", 8'h04, 32'h09);
    wb_read_chk("t2_digest_cleared", 8'h20, 32'h0);
    wb_write(8'h08, 32'h77);
    wb_read_chk("t2_len_write_busy_ignored", 8'h08, 32'h0);
    dig_strobes(8, 32'h2200_0000, 1);
    idle_cycles(3);
    model_busy = 0;
    wb_read_chk("t2_status_done", 8'h04, 32'h0A);
    wb_read_chk("t2_digest7", 8'h3C, 32'h2200_0007);
    check("t2_no_valid", valid_cycles - v0, 0);
    check("t2_start_pulses", start_pulses, 2);

    // 3: overflow the FIFO with nine pushes
    core_ready = 0;
    for (int i = 0; i < 9; i++) wb_write(8'h0C, 32'h3000_0000 + i);
    wb_read_chk("t3_full_ovf", 8'h04, 32'h16);
    wb_write(8'h04, 32'h10);
    wb_read_chk("t3_ovf_cleared", 8'h04, 32'h06);
    core_ready = 1;
    wb_write(8'h08, 32'd32);
    b0 = beats_seen;
    start_job(8);
    wait_drain("t3_drain");
    check("t3_beats", beats_seen - b0, 8);
    idle_cycles(2);
    wb_read_chk("t3_ninth_lost", 8'h04, 32'h09);
    dig_strobes(8, 32'h3300_0000, 1);
    idle_cycles(3);
    model_busy = 0;
    wb_read_chk("t3_status_done", 8'h04, 32'h0A);

    // 4: abort mid-absorb with the core stalled
    core_ready = 0;
    wb_write(8'h08, 32'd8);
    wb_write(8'h0C, 32'h4400_0001);
    start_job(2);
    idle_cycles(4);
    check("t4_valid_stalled", {31'h0, core_valid}, 32'h1);
    a0 = abort_pulses;
    wb_write(8'h00, 32'h2);
    exp_q.delete(); beats_left = 0; model_busy = 0;
    idle_cycles(2);
    check("t4_abort_pulse", abort_pulses - a0, 1);
    wb_read_chk("t4_status", 8'h04, 32'h08);
    core_ready = 1;
    s0 = start_pulses;
    wb_write(8'h00, 32'h3);
    idle_cycles(2);
    check("abort_beats_start", start_pulses - s0, 0);
    check("abort_beats_start_pulse", abort_pulses - a0, 2);
    wb_read_chk("abort_beats_start_status", 8'h04, 32'h08);

    // 5: START while busy, then reset mid digest wait
    wb_write(8'h08, 32'h0);
    s0 = start_pulses;
    start_job(0);
    wb_write(8'h00, 32'h1);
    wb_read_chk("t5_start_err", 8'h04, 32'h29);
    dig_strobes(8, 32'h5500_0000, 1);
    idle_cycles(3);
    model_busy = 0;
    wb_read_chk("t5_done_kept_err", 8'h04, 32'h2A);
    wb_read_chk("t5_digest2", 8'h28, 32'h5500_0002);
    check("t5_one_start", start_pulses - s0, 1);
    start_job(0);
    dig_strobes(3, 32'h6600_0000, 0);
    @(posedge clk); #1;
    rst = 1; model_len = 0; model_busy = 0; exp_q.delete(); beats_left = 0;
    @(posedge clk); #1;
    rst = 0;
    check("t5_rst_outputs", {27'h0, ack, core_start, core_abort, core_valid, irq}, 32'h0);
    wb_read_chk("t5_rst_status", 8'h04, 32'h08);
    wb_read_chk("t5_rst_digest0", 8'h20, 32'h0);
    wb_read_chk("t5_rst_len", 8'h08, 32'h0);

`ifdef SHA3_JOB_IRQ_EN
    // 6: masked interrupt follows done
    wb_write(8'h10, 32'h1);
    wb_read_chk("t6_mask", 8'h10, 32'h1);
    start_job(0);
    dig_strobes(8, 32'h7700_0000, 1);
    idle_cycles(3);
    model_busy = 0;
    check("t6_irq_set", {31'h0, irq}, 32'h1);
    wb_write(8'h04, 32'h2);
    check("t6_irq_cleared", {31'h0, irq}, 32'h0);
`endif

    idle_cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
